aes128_iter_core: RTL and testbench



---
 rtl/aes_pkg.sv | 62 ++++++
 rtl/aes_key_step.sv | 27 ++
 rtl/aes_sub_bytes.sv | 14 +
 rtl/aes128_iter_core.sv | 102 ++++++++++
 tb/tb_aes128_iter_core.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: round count, round-constant table, S-box,
// GF(2^8) helpers, ShiftRows / MixColumns functions and the core FSM states.
// Byte i of a 128-bit block sits at [127-8*i -: 8]; byte i is row i%4, column i/4.
package aes_pkg;

    localparam int unsigned NR = 10;

    typedef enum logic [1:0] {IDLE, RUN, DONE} aes_state_e;

    // RCON[1] in the top byte through RCON[10] in the bottom byte
    localparam logic [79:0] RCON = 80'h01020408102040801b36;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[2047 - 8 * int'(b) -: 8];
    endfunction

    // Round constant for rounds 1..NR; anything else yields 0.
    function automatic logic [7:0] get_rcon(input logic [3:0] rnd);
        int r;
        r = int'(rnd);
        if (r < 1 || r > int'(NR)) return 8'h00;
        return RCON[8 * (int'(NR) - r) +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One column, row 0 in [31:24].
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[127 - 8 * (r + 4 * c) -: 8] = s[127 - 8 * (r + 4 * ((c + r) % 4)) -: 8];
            end
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// One step of AES-128 key expansion: next round key from current key and rcon.
// Ports: rk (current round key, w0 in [127:96]), rcon (round constant),
// rk_n (next round key). Purely combinational.
module aes_key_step
    import aes_pkg::*;
(
    input  logic [127:0] rk,
    input  logic [7:0]   rcon,
    output logic [127:0] rk_n
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot, sub;
    logic [31:0] n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = rk;
    assign rot = {w3[23:0], w3[31:24]};
    assign sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};

    assign n0 = w0 ^ sub ^ {rcon, 24'h0};
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign rk_n = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_sub_bytes.sv
// SubBytes stage: sixteen parallel S-box lookups on a 128-bit state.
// Ports: data (state in), result (substituted state out). Purely combinational.
module aes_sub_bytes
    import aes_pkg::*;
(
    input  logic [127:0] data,
    output logic [127:0] result
);

    for (genvar i = 0; i < 16; i++) begin : g_byte
        assign result[8 * i +: 8] = sbox(data[8 * i +: 8]);
    end

endmodule

// File: rtl/aes128_iter_core.sv
// Iterative AES-128 encryption core, one round per clock.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_block/in_key accept a
// plaintext and key; out_valid/out_ready/out_block deliver the ciphertext;
// busy is high while a block is in RUN or DONE.
module aes128_iter_core
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_block,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_block,
    output logic         busy
);

    localparam logic [3:0] LastRnd = 4'(NR);

    aes_state_e   fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [127:0] rk_q, rk_d;
    logic [3:0]   rnd_q, rnd_d;

    logic [127:0] sb, sr, mixed, rk_n, round_out;

    aes_sub_bytes u_sub_bytes (
        .data   (state_q),
        .result (sb)
    );

    aes_key_step u_key_step (
        .rk   (rk_q),
        .rcon (get_rcon(rnd_q)),
        .rk_n (rk_n)
    );

    assign sr = shift_rows(sb);

    always_comb begin
        mixed = '0;
        for (int c = 0; c < 4; c++) begin
            mixed[127 - 32 * c -: 32] = mix_column(sr[127 - 32 * c -: 32]);
        end
    end

    // Final round skips MixColumns.
    assign round_out = ((rnd_q == LastRnd) ? sr : mixed) ^ rk_n;

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        rk_d    = rk_q;
        rnd_d   = rnd_q;
        case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = in_block ^ in_key;
                    rk_d    = in_key;
                    rnd_d   = 4'd1;
                    fsm_d   = RUN;
                end
            end
            RUN: begin
                state_d = round_out;
                rk_d    = rk_n;
                if (rnd_q == LastRnd) begin
                    fsm_d = DONE;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            DONE: begin
                // No same-cycle accept: a new block waits for IDLE.
                if (out_ready) fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            rk_q    <= '0;
            rnd_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            rk_q    <= rk_d;
            rnd_q   <= rnd_d;
        end
    end

    assign in_ready  = (fsm_q == IDLE);
    assign out_valid = (fsm_q == DONE);
    assign busy      = (fsm_q == RUN) || (fsm_q == DONE);
    assign out_block = state_q;

endmodule

// File: tb/tb_aes128_iter_core.sv
// Self-checking bench for aes128_iter_core: FIPS-197 vectors, timing, backpressure,
// reset mid-run, input changes in flight and random blocks against a byte-level
// AES model whose S-box is derived from GF(2^8) inversion plus the affine map.
module tb_aes128_iter_core;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] in_block, in_key, out_block;

    always #5 clk = ~clk;

    aes128_iter_core dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_block  (in_block),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_block (out_block),
        .busy      (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] sbox_tab [256];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic model(input logic [127:0] key, input logic [127:0] pt,
                         output logic [127:0] ct, output logic [127:0] last_rk);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        logic [7:0]  s [16];
        logic [7:0]  u [16];
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]],
                     sbox_tab[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8 * i -: 8] ^ key[127 - 8 * i -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_tab[s[i]];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) u[r + 4 * c] = s[r + 4 * ((c + r) % 4)];
            for (int c = 0; c < 4; c++) begin
                for (int r = 0; r < 4; r++) begin
                    if (rnd < 10)
                        s[4 * c + r] = gmul(8'h02, u[4 * c + r])
                                     ^ gmul(8'h03, u[4 * c + (r + 1) % 4])
                                     ^ u[4 * c + (r + 2) % 4] ^ u[4 * c + (r + 3) % 4];
                    else
                        s[4 * c + r] = u[4 * c + r];
                end
            end
            for (int i = 0; i < 16; i++)
                s[i] = s[i] ^ w[4 * rnd + i / 4][31 - 8 * (i % 4) -: 8];
        end
        for (int i = 0; i < 16; i++) ct[127 - 8 * i -: 8] = s[i];
        last_rk = {w[40], w[41], w[42], w[43]};
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check({tag, "_ready_timeout"}, 128'(in_ready), 128'd1);
    endtask

    // Runs one block: accept, check latency/result/rk, hold off for bp cycles, handshake.
    task automatic do_block(input string tag, input logic [127:0] key, input logic [127:0] pt,
                            input int bp, input bit scramble,
                            input bit has_ct, input logic [127:0] fixed_ct,
                            input bit has_rk, input logic [127:0] fixed_rk);
        logic [127:0] exp_ct, exp_rk;
        int cnt;
        model(key, pt, exp_ct, exp_rk);
        if (has_ct) check({tag, "_model_vs_fips"}, exp_ct, fixed_ct);
        wait_ready(tag);
        in_valid  = 1'b1;
        in_block  = pt;
        in_key    = key;
        out_ready = 1'b0;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
            if (scramble) begin
                in_block = rnd128();
                in_key   = rnd128();
                in_valid = 1'($urandom_range(0, 1));
            end else begin
                in_valid = 1'b0;
            end
            if (cnt == 1) begin
                check({tag, "_busy_run"}, 128'(busy), 128'd1);
                check({tag, "_ready_run"}, 128'(in_ready), 128'd0);
            end
        end while (!out_valid && cnt < 40);
        check({tag, "_latency"}, 128'(cnt), 128'd11);
        check({tag, "_ct"}, out_block, exp_ct);
        if (has_ct) check({tag, "_ct_fips"}, out_block, fixed_ct);
        check({tag, "_rk10"}, dut.rk_q, exp_rk);
        if (has_rk) check({tag, "_rk10_fips"}, dut.rk_q, fixed_rk);
        for (int i = 0; i < bp; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_block = rnd128();
            in_key   = rnd128();
            @(negedge clk);
            check({tag, "_bp_valid"}, 128'(out_valid), 128'd1);
            check({tag, "_bp_ready"}, 128'(in_ready), 128'd0);
            check({tag, "_bp_block"}, out_block, exp_ct);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_hs_valid"}, 128'(out_valid), 128'd0);
        check({tag, "_hs_ready"}, 128'(in_ready), 128'd1);
        check({tag, "_hs_busy"}, 128'(busy), 128'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [127:0] k, p, ct, lrk;
        int t0, t1, n;

        build_sbox();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_block = '0; in_key = '0;
        #1;
        check("rst_in_ready", 128'(in_ready), 128'd1);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_out_block", out_block, 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_block("c1", 128'h000102030405060708090a0b0c0d0e0f,
                 128'h00112233445566778899aabbccddeeff, 0, 1'b0,
                 1'b1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b0, '0);
        do_block("appb", 128'h2b7e151628aed2a6abf7158809cf4f3c,
                 128'h3243f6a8885a308d313198a2e0370734, 0, 1'b0,
                 1'b1, 128'h3925841d02dc09fbdc118597196a0b32,
                 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        do_block("zero", '0, '0, 0, 1'b0, 1'b1, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 1'b0, '0);

        // Back-to-back with out_ready held high: accepts 12 cycles apart.
        wait_ready("b2b");
        in_valid = 1'b1; in_block = '0; in_key = '0; out_ready = 1'b1;
        t0 = -1; t1 = -1; n = 0;
        do begin
            if (in_ready) begin
                if (t0 < 0) t0 = n;
                else t1 = n;
            end
            @(negedge clk);
            n++;
        end while (t1 < 0 && n < 60);
        in_valid = 1'b0;
        check("b2b_spacing", 128'(t1 - t0), 128'd12);
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("b2b_ct", out_block, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
        @(negedge clk);
        check("b2b_idle", 128'(in_ready), 128'd1);
        out_ready = 1'b0;

        // Backpressure for 20 cycles with stray in_valid pulses.
        do_block("bp", rnd128(), rnd128(), 20, 1'b0, 1'b0, '0, 1'b0, '0);

        // Reset in the middle of a block: outputs clear without a clock edge.
        wait_ready("rstmid");
        in_valid = 1'b1; in_block = rnd128(); in_key = rnd128();
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstmid_in_ready", 128'(in_ready), 128'd1);
        check("rstmid_out_valid", 128'(out_valid), 128'd0);
        check("rstmid_out_block", out_block, 128'd0);
        check("rstmid_busy", 128'(busy), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_block("appb2", 128'h2b7e151628aed2a6abf7158809cf4f3c,
                 128'h3243f6a8885a308d313198a2e0370734, 0, 1'b0,
                 1'b1, 128'h3925841d02dc09fbdc118597196a0b32,
                 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Inputs change every cycle while the block is in flight.
        do_block("scram", rnd128(), rnd128(), 2, 1'b1, 1'b0, '0, 1'b0, '0);

        for (int i = 0; i < 6; i++) begin
            k = rnd128();
            p = rnd128();
            do_block($sformatf("rand%0d", i), k, p, int'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), 1'b0, '0, 1'b0, '0);
        end
        model(128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
              ct, lrk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
